// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the byte-to-128-bit loader.
package loader_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;
    localparam int IDX_W     = 4;
    localparam int VEC_W     = BYTE_W * NUM_BYTES;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/byte_to_128bit_loader_decode.sv
// One-hot byte-lane write enable, gated by the write-accept condition.
module byte_lane_decode
    import loader_pkg::*;
(
    input  logic                 en,
    input  logic [IDX_W-1:0]     idx,
    output logic [NUM_BYTES-1:0] lane_en
);

    always_comb begin
        lane_en = '0;
        if (en) begin
            lane_en[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/byte_to_128bit_loader.sv
// Accumulates byte writes in a shadow vector and commits it atomically
// to a registered 128-bit output.
module byte_to_128bit_loader
    import loader_pkg::*;
#(
    parameter int AUTO_COMMIT = 1
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iClear,
    input  logic                 iWrEn,
    input  logic                 iIdxMode,
    input  logic [IDX_W-1:0]     ivIdx,
    input  logic [BYTE_W-1:0]    ivByte,
    input  logic                 iCommit,
    output logic [VEC_W-1:0]     ovSignals,
    output logic                 oUpdate,
    output logic [NUM_BYTES-1:0] ovByteMask,
    output logic                 oBusy,
    output logic                 oOverrun
);

    localparam logic AUTO = (AUTO_COMMIT != 0);

    logic [1:0]           state;
    logic [IDX_W-1:0]     ptr;
    logic [VEC_W-1:0]     shadow;
    logic [NUM_BYTES-1:0] mask;

    logic                 accept;
    logic [IDX_W-1:0]     target;
    logic [NUM_BYTES-1:0] lane_en;
    logic [NUM_BYTES-1:0] mask_set;
    logic                 trigger;

    assign accept   = iWrEn && !iClear && (state != ST_COMMIT);
    assign target   = iIdxMode ? ivIdx : ptr;
    assign mask_set = mask | lane_en;
    // A same-cycle write is already folded into mask_set and the shadow.
    assign trigger  = (state == ST_FILL)
                    && (iCommit || (AUTO && (&mask_set)));

    byte_lane_decode u_decode (
        .en      (accept),
        .idx     (target),
        .lane_en (lane_en)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (lane_en[i]) begin
                    shadow[i*BYTE_W +: BYTE_W] <= ivByte;
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            mask      <= '0;
            ovSignals <= '0;
            oUpdate   <= 1'b0;
            oOverrun  <= 1'b0;
        end else begin
            oUpdate <= 1'b0;
            if (iClear) begin
                state    <= ST_IDLE;
                ptr      <= '0;
                mask     <= '0;
                oOverrun <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            mask  <= mask_set;
                            ptr   <= target + IDX_W'(1);
                            state <= ST_FILL;
                        end
                    end
                    ST_FILL: begin
                        if (accept) begin
                            mask <= mask_set;
                            ptr  <= target + IDX_W'(1);
                        end
                        if (trigger) begin
                            state <= ST_COMMIT;
                        end
                    end
                    ST_COMMIT: begin
                        if (iWrEn) begin
                            oOverrun <= 1'b1;
                        end
                        ovSignals <= shadow;
                        oUpdate   <= 1'b1;
                        mask      <= '0;
                        ptr       <= '0;
                        state     <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ovByteMask = mask;
    assign oBusy      = (state != ST_IDLE);

endmodule
